// File: rtl/m90_pkg.sv
// Shared types and constants for the M90 interrupt controller.
package m90_pkg;

   typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} irq_state_t;
   typedef enum logic [1:0] {SRC_VBL, SRC_HINT, SRC_SND, SRC_NONE} irq_src_t;

   localparam logic [7:0] VEC_VBL  = 8'h18;
   localparam logic [7:0] VEC_HINT = 8'h19;
   localparam logic [7:0] VEC_SND  = 8'h1A;
   localparam logic [7:0] VEC_SPUR = 8'h1F;

   localparam logic [7:0] IO_MASK  = 8'h0A;
   localparam logic [7:0] IO_EOI   = 8'h0E;

   // Fixed priority: bit 0 (VBLANK) wins, bit 2 (sound) loses.
   function automatic irq_src_t prio_sel(input logic [2:0] req);
      irq_src_t s;
      if (req[0])      s = SRC_VBL;
      else if (req[1]) s = SRC_HINT;
      else if (req[2]) s = SRC_SND;
      else             s = SRC_NONE;
      return s;
   endfunction

   function automatic logic [7:0] src_vector(input irq_src_t s);
      logic [7:0] v;
      case (s)
         SRC_VBL:  v = VEC_VBL;
         SRC_HINT: v = VEC_HINT;
         SRC_SND:  v = VEC_SND;
         default:  v = VEC_SPUR;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/m90_irq_ctrl_edge_latch.sv
// Rising-edge detector with a sticky pending bit; a new edge wins over a clear.
module irq_edge_latch
   import m90_pkg::*;
(
   input  logic clk_sys,
   input  logic reset_n,
   input  logic src_i,
   input  logic clr_i,
   output logic pend_o
);

   logic src_q;
   logic pend_q;
   logic pend_d;

   // Set has priority so an edge coincident with a clear is never lost.
   always_comb begin
      pend_d = (src_i & ~src_q) | (pend_q & ~clr_i);
   end

   // Edge register tracks the input even in reset so no false edge follows reset.
   always_ff @(posedge clk_sys) begin
      src_q <= src_i;
      if (!reset_n) pend_q <= 1'b0;
      else          pend_q <= pend_d;
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/m90_irq_ctrl.sv
// Vectored interrupt controller for the V33: pending latches, mask, INTAK sequencer.
module m90_irq_ctrl
   import m90_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        vblank,
   input  logic        hint,
   input  logic        snd_irq,
   input  logic        io_wr,
   input  logic [7:0]  io_addr,
   input  logic [15:0] io_din,
   input  logic        n_intak,
   output logic        int_req,
   output logic [7:0]  int_vector,
   output logic [2:0]  pending
);

   logic       io_wr_q;
   logic       n_intak_q;
   logic [2:0] mask_q;
   irq_state_t state_q;
   irq_src_t   sel_q;
   logic [7:0] vector_q;
   logic       int_req_q;

   logic       wr_rise;
   logic       intak_fall;
   logic       intak_rise;
   logic [1:0] edge_src;
   logic [1:0] edge_pend;
   logic [1:0] clr_d;
   logic [2:0] active;
   logic       unused_io_bits;

   assign wr_rise    = io_wr & ~io_wr_q;
   assign intak_fall = ~n_intak & n_intak_q;
   assign intak_rise = n_intak & ~n_intak_q;
   assign edge_src   = {hint, vblank};
   assign pending    = {snd_irq, edge_pend};
   assign active     = pending & mask_q;
   assign unused_io_bits = ^io_din[15:3];

   // Clear sources: EOI write bits, or the selected edge source at the end of ACK2.
   always_comb begin
      clr_d = 2'b00;
      if (wr_rise && io_addr == IO_EOI)
         clr_d = clr_d | io_din[1:0];
      if (state_q == ACK2 && intak_rise) begin
         if (sel_q == SRC_VBL)  clr_d[0] = 1'b1;
         if (sel_q == SRC_HINT) clr_d[1] = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_latch
         irq_edge_latch u_latch (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .src_i   (edge_src[gi]),
            .clr_i   (clr_d[gi]),
            .pend_o  (edge_pend[gi])
         );
      end
   endgenerate

   // Strobe history; loaded from live inputs during reset so no edge is seen on release.
   always_ff @(posedge clk_sys) begin
      io_wr_q   <= io_wr;
      n_intak_q <= n_intak;
   end

   // Mask register, written once per CPU write on the IOWR rising edge.
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         mask_q <= 3'b000;
      else if (wr_rise && io_addr == IO_MASK)
         mask_q <= io_din[2:0];
   end

   // INTAK sequencer with registered request and vector; request is held low during the ack.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         sel_q     <= SRC_NONE;
         vector_q  <= VEC_SPUR;
         int_req_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (intak_fall) begin
                  state_q   <= ACK1;
                  sel_q     <= prio_sel(active);
                  vector_q  <= src_vector(prio_sel(active));
                  int_req_q <= 1'b0;
               end else begin
                  int_req_q <= |active;
               end
            end
            ACK1: begin
               int_req_q <= 1'b0;
               if (intak_rise) state_q <= GAP;
            end
            GAP: begin
               int_req_q <= 1'b0;
               if (intak_fall) state_q <= ACK2;
            end
            default: begin
               int_req_q <= 1'b0;
               if (intak_rise) state_q <= IDLE;
            end
         endcase
      end
   end

   assign int_req    = int_req_q;
   assign int_vector = vector_q;

endmodule

// File: tb/tb_m90_irq_ctrl.sv
// Directed bench for m90_irq_ctrl with hand-computed expectations.
module tb_m90_irq_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        vblank  = 1'b0;
   logic        hint    = 1'b0;
   logic        snd_irq = 1'b0;
   logic        io_wr   = 1'b0;
   logic [7:0]  io_addr = 8'h00;
   logic [15:0] io_din  = 16'h0000;
   logic        n_intak = 1'b1;
   logic        int_req;
   logic [7:0]  int_vector;
   logic [2:0]  pending;

   int checks   = 0;
   int failures = 0;

   m90_irq_ctrl dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .vblank     (vblank),
      .hint,
      .snd_irq    (snd_irq),
      .io_wr      (io_wr),
      .io_addr    (io_addr),
      .io_din     (io_din),
      .n_intak    (n_intak),
      .int_req    (int_req),
      .int_vector (int_vector),
      .pending    (pending)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic io_write(input logic [7:0] addr, input logic [15:0] data);
      io_addr = addr;
      io_din  = data;
      io_wr   = 1'b1;
      tick(3);
      io_wr   = 1'b0;
      tick(1);
      $display("io_write addr=%h data=%h", addr, data);
   endtask

   task automatic ack_pair(input string tag, input logic [7:0] exp_vec);
      n_intak = 1'b0;
      tick(2);
      chk({tag, "_vec_ack1"}, {8'h00, int_vector}, {8'h00, exp_vec});
      chk({tag, "_req_ack1"}, {15'h0, int_req}, 16'h0);
      n_intak = 1'b1;
      tick(2);
      n_intak = 1'b0;
      tick(2);
      n_intak = 1'b1;
      tick(1);
      chk({tag, "_vec_done"}, {8'h00, int_vector}, {8'h00, exp_vec});
      $display("ack_pair %s vector=%h pending=%b", tag, int_vector, pending);
   endtask

   initial begin
      // 1: reset state, single VBLANK interrupt
      tick(3);
      chk("rst_pending", {13'h0, pending}, 16'h0);
      chk("rst_req", {15'h0, int_req}, 16'h0);
      chk("rst_vec", {8'h0, int_vector}, 16'h001F);
      reset_n = 1'b1;
      tick(1);
      io_write(8'h0A, 16'h0001);
      vblank = 1'b1;
      tick(1);
      chk("t1_pend_set", {13'h0, pending}, 16'h0001);
      chk("t1_req_lat1", {15'h0, int_req}, 16'h0);
      tick(1);
      chk("t1_req", {15'h0, int_req}, 16'h1);
      ack_pair("t1", 8'h18);
      chk("t1_pend_clr", {13'h0, pending}, 16'h0);
      tick(1);
      chk("t1_req_off", {15'h0, int_req}, 16'h0);

      // 2: simultaneous VBLANK and raster edges, priority order
      vblank = 1'b0;
      tick(1);
      io_write(8'h0A, 16'h0003);
      vblank = 1'b1;
      hint   = 1'b1;
      tick(2);
      chk("t2_pend", {13'h0, pending}, 16'h0003);
      chk("t2_req", {15'h0, int_req}, 16'h1);
      ack_pair("t2a", 8'h18);
      chk("t2_pend_a", {13'h0, pending}, 16'h0002);
      tick(1);
      chk("t2_req_a", {15'h0, int_req}, 16'h1);
      ack_pair("t2b", 8'h19);
      chk("t2_pend_b", {13'h0, pending}, 16'h0);
      tick(1);
      chk("t2_req_b", {15'h0, int_req}, 16'h0);
      vblank = 1'b0;
      hint   = 1'b0;
      tick(1);

      // 3: masked source stays pending, unmask raises request
      io_write(8'h0A, 16'h0000);
      hint = 1'b1;
      tick(3);
      chk("t3_req_masked", {15'h0, int_req}, 16'h0);
      chk("t3_pend", {13'h0, pending}, 16'h0002);
      io_addr = 8'h0A;
      io_din  = 16'h0002;
      io_wr   = 1'b1;
      tick(1);
      chk("t3_req_lat", {15'h0, int_req}, 16'h0);
      tick(1);
      chk("t3_req_unmask", {15'h0, int_req}, 16'h1);
      io_wr = 1'b0;
      tick(1);
      io_write(8'h0E, 16'h0002);
      chk("t3_eoi", {13'h0, pending}, 16'h0);
      hint = 1'b0;
      tick(1);

      // 4: EOI clear coincident with a new edge leaves the bit set
      io_write(8'h0A, 16'h0001);
      vblank = 1'b1;
      tick(1);
      vblank = 1'b0;
      tick(1);
      chk("t4_pend_pre", {13'h0, pending}, 16'h0001);
      io_addr = 8'h0E;
      io_din  = 16'h0001;
      io_wr   = 1'b1;
      vblank  = 1'b1;
      tick(1);
      chk("t4_set_wins", {13'h0, pending}, 16'h0001);
      io_wr = 1'b0;
      tick(1);
      io_write(8'h0E, 16'h0001);
      chk("t4_eoi_clear", {13'h0, pending}, 16'h0);
      vblank = 1'b0;
      tick(1);

      // 5: spurious ack, then level-sensitive sound source
      ack_pair("t5_spur", 8'h1F);
      chk("t5_spur_pend", {13'h0, pending}, 16'h0);
      io_write(8'h0A, 16'h0004);
      snd_irq = 1'b1;
      tick(1);
      chk("t5_snd_pend", {13'h0, pending}, 16'h0004);
      chk("t5_snd_req", {15'h0, int_req}, 16'h1);
      ack_pair("t5_snd1", 8'h1A);
      chk("t5_snd_kept", {13'h0, pending}, 16'h0004);
      tick(1);
      chk("t5_snd_req2", {15'h0, int_req}, 16'h1);
      ack_pair("t5_snd2", 8'h1A);
      snd_irq = 1'b0;
      tick(2);
      chk("t5_snd_off", {15'h0, int_req}, 16'h0);
      ack_pair("t5_spur2", 8'h1F);

      // 6: reset during GAP, then a normal acknowledge
      io_write(8'h0A, 16'h0001);
      vblank = 1'b1;
      tick(2);
      chk("t6_req", {15'h0, int_req}, 16'h1);
      n_intak = 1'b0;
      tick(2);
      chk("t6_vec_ack1", {8'h0, int_vector}, 16'h0018);
      n_intak = 1'b1;
      tick(1);
      reset_n = 1'b0;
      tick(1);
      chk("t6_rst_vec", {8'h0, int_vector}, 16'h001F);
      chk("t6_rst_pend", {13'h0, pending}, 16'h0);
      chk("t6_rst_req", {15'h0, int_req}, 16'h0);
      reset_n = 1'b1;
      tick(2);
      chk("t6_no_false_edge", {13'h0, pending}, 16'h0);
      io_write(8'h0A, 16'h0001);
      vblank = 1'b0;
      tick(1);
      vblank = 1'b1;
      tick(2);
      chk("t6_req2", {15'h0, int_req}, 16'h1);
      ack_pair("t6", 8'h18);
      chk("t6_pend_clr", {13'h0, pending}, 16'h0);
      tick(1);
      chk("t6_req_off", {15'h0, int_req}, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
